// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer.
// Holds the state encoding, RV32I opcode constants and the mux/ALU-op encodings.
// Also provides the wait-counter width helper used by the counter sub-module.
package multicycle_control_fsm_pkg;

    // Sequencer states (3-bit encoding)
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXEC      = 3'd2,
        ST_MEM_ACC   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_PC_UPDATE = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    // alu_op encodings consumed by the ALU control unit
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_BR    = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU operand selects
    localparam logic       SRC_A_PC     = 1'b0;
    localparam logic       SRC_A_REG    = 1'b1;
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;

    // PC input selects
    localparam logic [1:0] PC_SRC_ALU       = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PC_SRC_ALU_ALIGN = 2'b10;

    // Counter width able to hold MEM_WAIT, never narrower than one bit
    function automatic int unsigned wait_cnt_width(input int unsigned mem_wait);
        int unsigned n;
        n = $clog2(mem_wait + 1);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer and the multi-cycle datapath.
// master = sequencer side (drives strobes/selects), slave = datapath side.
// Purely combinational wiring; no storage.
interface multicycle_control_fsm_if;

    // datapath status into the sequencer
    logic [6:0] opcode;
    logic       bcond;
    logic       halt_req;

    // sequencer controls into the datapath
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       is_halted;

    modport master (
        input  opcode, bcond, halt_req,
        output pc_write, pc_source, iord, mem_read, mem_write, ir_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, is_halted
    );

    modport slave (
        output opcode, bcond, halt_req,
        input  pc_write, pc_source, iord, mem_read, mem_write, ir_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, is_halted
    );

endinterface

// File: rtl/multicycle_control_fsm_mem_wait_counter.sv
// Memory wait-state counter: loads MEM_WAIT, counts down, flags the final access cycle.
// Latency: last_o is combinational from the count register.
// No backpressure; holds at zero until reloaded.
module multicycle_control_fsm_mem_wait_counter
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic count_en_i,
    output logic last_o
);

    localparam int unsigned   CW       = wait_cnt_width(MEM_WAIT);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_WAIT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    logic [CW-1:0] cnt_q;

    // Reload on entry to a memory state, otherwise count down to zero while accessing
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= CNT_INIT;
        end else if (load_i) begin
            cnt_q <= CNT_INIT;
        end else if (count_en_i && (cnt_q != CNT_ZERO)) begin
            cnt_q <= cnt_q - CNT_ONE;
        end
    end

    assign last_o = (cnt_q == CNT_ZERO);

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM_ACC/WRITEBACK/PC_UPDATE, sticky HALT.
// Controls decode combinationally from the current state (branch pc_write also from bcond).
// Memory accesses stretch by MEM_WAIT cycles; reset low forces every strobe and select to 0.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_control_fsm_if.master       bus
);

    state_e     state_q;
    state_e     state_d;
    logic       halted_q;

    logic       wait_last;
    logic       wait_load;
    logic       wait_count;

    logic       pc_write_c;
    logic [1:0] pc_source_c;
    logic       iord_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic       mem_to_reg_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;

    // A fresh wait window starts whenever we move into a memory state from elsewhere
    assign wait_load  = (state_d != state_q) &&
                        ((state_d == ST_FETCH) || (state_d == ST_MEM_ACC));
    assign wait_count = (state_q == ST_FETCH) || (state_q == ST_MEM_ACC);

    multicycle_control_fsm_mem_wait_counter #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .clk        (clk),
        .reset      (reset),
        .load_i     (wait_load),
        .count_en_i (wait_count),
        .last_o     (wait_last)
    );

    // Next-state and control decode; reset low overrides every control
    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        pc_source_c  = PC_SRC_ALU;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = SRC_A_PC;
        alu_src_b_c  = SRC_B_REG;
        alu_op_c     = ALU_OP_ADD;

        unique case (state_q)
            ST_FETCH: begin
                mem_read_c = 1'b1;
                if (wait_last) begin
                    ir_write_c = 1'b1;
                    state_d    = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // ALUOut <= PC + imm, used later as branch/jump target
                alu_src_b_c = SRC_B_IMM;
                if (bus.opcode == OP_ECALL) begin
                    state_d = bus.halt_req ? ST_HALT : ST_PC_UPDATE;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                unique case (bus.opcode)
                    OP_ARITH: begin
                        alu_src_a_c = SRC_A_REG;
                        alu_op_c    = ALU_OP_FUNCT;
                        state_d     = ST_WRITEBACK;
                    end
                    OP_ARITH_IMM: begin
                        alu_src_a_c = SRC_A_REG;
                        alu_src_b_c = SRC_B_IMM;
                        alu_op_c    = ALU_OP_FUNCT;
                        state_d     = ST_WRITEBACK;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a_c = SRC_A_REG;
                        alu_src_b_c = SRC_B_IMM;
                        state_d     = ST_MEM_ACC;
                    end
                    OP_BRANCH: begin
                        alu_src_a_c = SRC_A_REG;
                        alu_op_c    = ALU_OP_BR;
                        if (bus.bcond) begin
                            pc_write_c  = 1'b1;
                            pc_source_c = PC_SRC_ALUOUT;
                            state_d     = ST_FETCH;
                        end else begin
                            state_d = ST_PC_UPDATE;
                        end
                    end
                    OP_JAL, OP_JALR: begin
                        // ALUOut <= PC + 4, the link value
                        alu_src_b_c = SRC_B_FOUR;
                        state_d     = ST_WRITEBACK;
                    end
                    default: begin
                        // unrecognised opcode behaves as a NOP
                        state_d = ST_PC_UPDATE;
                    end
                endcase
            end

            ST_MEM_ACC: begin
                iord_c      = 1'b1;
                mem_read_c  = (bus.opcode == OP_LOAD);
                mem_write_c = (bus.opcode == OP_STORE);
                if (wait_last) begin
                    state_d = (bus.opcode == OP_LOAD) ? ST_WRITEBACK : ST_PC_UPDATE;
                end
            end

            ST_WRITEBACK: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = (bus.opcode == OP_LOAD);
                if (bus.opcode == OP_JAL) begin
                    alu_src_b_c = SRC_B_IMM;
                    pc_write_c  = 1'b1;
                    pc_source_c = PC_SRC_ALU;
                    state_d     = ST_FETCH;
                end else if (bus.opcode == OP_JALR) begin
                    alu_src_a_c = SRC_A_REG;
                    alu_src_b_c = SRC_B_IMM;
                    pc_write_c  = 1'b1;
                    pc_source_c = PC_SRC_ALU_ALIGN;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_PC_UPDATE;
                end
            end

            ST_PC_UPDATE: begin
                alu_src_b_c = SRC_B_FOUR;
                pc_write_c  = 1'b1;
                pc_source_c = PC_SRC_ALU;
                state_d     = ST_FETCH;
            end

            ST_HALT: begin
                // parked until reset; all inputs ignored
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (!reset) begin
            pc_write_c   = 1'b0;
            pc_source_c  = 2'b00;
            iord_c       = 1'b0;
            mem_read_c   = 1'b0;
            mem_write_c  = 1'b0;
            ir_write_c   = 1'b0;
            reg_write_c  = 1'b0;
            mem_to_reg_c = 1'b0;
            alu_src_a_c  = 1'b0;
            alu_src_b_c  = 2'b00;
            alu_op_c     = 2'b00;
        end
    end

    // State register and sticky halt flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_FETCH;
            halted_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ST_HALT) begin
                halted_q <= 1'b1;
            end
        end
    end

    assign bus.pc_write   = pc_write_c;
    assign bus.pc_source  = pc_source_c;
    assign bus.iord       = iord_c;
    assign bus.mem_read   = mem_read_c;
    assign bus.mem_write  = mem_write_c;
    assign bus.ir_write   = ir_write_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.alu_op     = alu_op_c;
    assign bus.is_halted  = halted_q;

endmodule
